// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, error-bit positions and
// the oversample-tick divisor calculation used by both RX and TX.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    localparam int unsigned RX_ERR_BREAK  = 0;
    localparam int unsigned RX_ERR_PARITY = 1;
    localparam int unsigned RX_ERR_FRAME  = 2;

    // Rounded clocks per sample tick, never below 1.
    function automatic int unsigned calc_divisor(input int unsigned sysclk,
                                                 input int unsigned baud,
                                                 input int unsigned os);
        int unsigned den;
        int unsigned div;
        den = baud * os;
        if (den == 0) begin
            return 1;
        end
        div = (sysclk + den / 2) / den;
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divisor counter producing a one-cycle tick every DIVISOR clocks;
// clear restarts the count so the first tick lands DIVISOR cycles later.
module uart_baud_tick #(
    parameter int unsigned DIVISOR = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIVISOR + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIVISOR - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: majority-voted bit sampling, parity/frame/break
// checking, and a one-cycle Data_Rdy strobe per completed frame.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned SYSCLK_RATE = 100000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_BIT  = 1,
    parameter int unsigned STOP_BITS   = 2,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 Rx_Busy
);

    localparam int unsigned DIV = calc_divisor(SYSCLK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned PW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = 4;
    localparam int unsigned MID = OVERSAMPLE / 2;

    rx_state_e            state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [1:0]           sync_vld;
    logic                 armed;
    logic                 tick;
    logic [PW-1:0]        phase;
    logic [BW-1:0]        bit_cnt;
    logic                 vote_a;
    logic                 vote_b;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;
    logic                 par_err;
    logic                 frm_err;
    logic                 all_zero;

    logic                 start_c;
    logic                 sampling_c;
    logic                 decide_c;
    logic                 vote_c;
    logic                 brk_c;
    logic                 frm_c;
    logic [2:0]           err_c;

    // Two-flop synchronizer plus edge register; armed blocks a line held low
    // across reset release from looking like a start edge.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            sync_vld <= '0;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= Rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | (sync_vld[1] & rx_s);
        end
    end

    uart_baud_tick #(
        .DIVISOR(DIV)
    ) u_tick (
        .clk  (Clk),
        .rst_n(Rst),
        .clear(start_c),
        .tick (tick)
    );

    assign start_c    = (state == IDLE) && armed && rx_prev && !rx_s;
    assign sampling_c = (state == START) || (state == DATA) ||
                        (state == PARITY) || (state == STOP);
    assign decide_c   = sampling_c && tick && (phase == PW'(MID + 1));
    assign vote_c     = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
    assign brk_c      = all_zero & ~vote_c;
    assign frm_c      = frm_err | ~vote_c;

    always_comb begin
        err_c = '0;
        if (brk_c) begin
            err_c[RX_ERR_BREAK] = 1'b1;
        end else begin
            err_c[RX_ERR_PARITY] = par_err;
            err_c[RX_ERR_FRAME]  = frm_c;
        end
    end

    // Receive FSM; phase counts sample ticks within the current bit.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            vote_a   <= 1'b1;
            vote_b   <= 1'b1;
            shift    <= '0;
            par_acc  <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            all_zero <= 1'b0;
            Data_Out <= '0;
            Data_Rdy <= 1'b0;
            Rx_Error <= '0;
            Rx_Busy  <= 1'b0;
        end else begin
            Data_Rdy <= 1'b0;
            if (tick && phase == PW'(MID - 1)) vote_a <= rx_s;
            if (tick && phase == PW'(MID))     vote_b <= rx_s;
            if (sampling_c && tick) begin
                phase <= (phase == PW'(OVERSAMPLE - 1)) ? '0 : phase + PW'(1);
            end

            case (state)
                IDLE: begin
                    if (start_c) begin
                        state    <= START;
                        phase    <= '0;
                        bit_cnt  <= '0;
                        par_acc  <= 1'b0;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                        all_zero <= 1'b1;
                        Rx_Busy  <= 1'b1;
                    end
                end
                START: begin
                    if (decide_c) begin
                        if (vote_c) begin
                            state   <= IDLE;
                            Rx_Busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (decide_c) begin
                        shift    <= {shift[DATA_BITS-2:0], vote_c};
                        par_acc  <= par_acc ^ vote_c;
                        all_zero <= all_zero & ~vote_c;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_BIT != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (decide_c) begin
                        par_err  <= (vote_c != par_acc);
                        all_zero <= all_zero & ~vote_c;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (decide_c) begin
                        if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            Data_Rdy <= 1'b1;
                            Data_Out <= brk_c ? '0 : shift;
                            Rx_Error <= err_c;
                            Rx_Busy  <= brk_c;
                            phase    <= '0;
                            state    <= brk_c ? BRK_WAIT : IDLE;
                        end else begin
                            bit_cnt  <= bit_cnt + BW'(1);
                            frm_err  <= frm_c;
                            all_zero <= brk_c;
                        end
                    end
                end
                BRK_WAIT: begin
                    // Leave only after a full bit time of continuous idle-high.
                    if (!rx_s) begin
                        phase <= '0;
                    end else if (tick) begin
                        if (phase == PW'(OVERSAMPLE - 1)) begin
                            phase   <= '0;
                            state   <= IDLE;
                            Rx_Busy <= 1'b0;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Rx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized and directed bench for uart_rx_frame against a frame-level model
// that derives data and error bits from the line levels of each bit.
module tb_uart_rx_frame;

    localparam int BIT_CYC = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_rdy;
    logic [2:0] rx_error;
    logic       rx_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];

    uart_rx_frame #(
        .SYSCLK_RATE(1600000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .PARITY_BIT (1),
        .STOP_BITS  (2),
        .OVERSAMPLE (16)
    ) dut (
        .Clk     (clk),
        .Rst     (rst_n),
        .Rx      (rx),
        .Data_Out(data_out),
        .Data_Rdy(data_rdy),
        .Rx_Error(rx_error),
        .Rx_Busy (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && data_rdy) got_q.push_back({rx_error, data_out});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {err[2:0], data} from the levels seen on the line.
    function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic p,
                                              input logic [1:0] st);
        if (d == 8'h00 && p == 1'b0 && st == 2'b00) return {3'b001, 8'h00};
        return {~(st[1] & st[0]), (p != ^d), 1'b0, d};
    endfunction

    task automatic line_bit(input logic v, input int glitch_off);
        for (int c = 0; c < BIT_CYC; c++) begin
            @(posedge clk);
            rx = (c == glitch_off) ? ~v : v;
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) line_bit(1'b1, -1);
    endtask

    // Start bit, data MSB first, parity, first stop st[1], last stop st[0].
    task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] st,
                              input int glitch_bit);
        line_bit(1'b0, -1);
        for (int i = 7; i >= 0; i--) line_bit(d[i], (glitch_bit == 7 - i) ? 11 : -1);
        line_bit(p, -1);
        line_bit(st[1], -1);
        line_bit(st[0], -1);
        exp_q.push_back(ref_frame(d, p, st));
    endtask

    task automatic check_frames(input string tag);
        repeat (8) @(posedge clk);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [10:0] g;
            logic [10:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(g[7:0]), 32'(e[7:0]));
            chk({tag, "_err"}, 32'(g[10:8]), 32'(e[10:8]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        logic [1:0] st;
        int         gap;
        bit         busy_low;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_data", 32'(data_out), 32'h0);
        chk("reset_err", 32'(rx_error), 32'h0);
        chk("reset_rdy", 32'(data_rdy), 32'h0);
        chk("reset_busy", 32'(rx_busy), 32'h0);
        rst_n = 1'b1;
        idle_bits(2);

        send_frame(8'hA5, 1'b0, 2'b11, -1);
        idle_bits(1);
        check_frames("good_a5");

        send_frame(8'hAA, 1'b1, 2'b11, -1);
        idle_bits(1);
        check_frames("parity_aa");

        send_frame(8'h3C, 1'b0, 2'b01, -1);
        idle_bits(1);
        check_frames("frame_3c");

        // Break: 40 bit times low, then back to idle-high.
        for (int i = 0; i < 40; i++) begin
            line_bit(1'b0, -1);
            if (i == 30) begin
                @(negedge clk);
                chk("break_busy_held", 32'(rx_busy), 32'h1);
            end
        end
        exp_q.push_back(ref_frame(8'h00, 1'b0, 2'b00));
        idle_bits(2);
        chk("break_busy_released", 32'(rx_busy), 32'h0);
        check_frames("break");
        send_frame(8'h55, 1'b0, 2'b11, -1);
        idle_bits(1);
        check_frames("after_break_55");

        // Short low glitch while idle must be rejected as a false start.
        @(posedge clk);
        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        busy_low = 1'b0;
        for (int i = 0; i < 8 * BIT_CYC && !busy_low; i++) begin
            @(negedge clk);
            if (i > 12 && !rx_busy) busy_low = 1'b1;
        end
        chk("glitch_busy_clears", 32'(busy_low), 32'h1);
        check_frames("idle_glitch");

        send_frame(8'h96, 1'b0, 2'b11, 3);
        idle_bits(1);
        check_frames("data_glitch");

        // Reset during data bit 4 discards the frame.
        line_bit(1'b0, -1);
        for (int i = 7; i >= 4; i--) line_bit(1'b1, -1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("midframe_busy", 32'(rx_busy), 32'h1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset_data", 32'(data_out), 32'h0);
        chk("midreset_err", 32'(rx_error), 32'h0);
        chk("midreset_busy", 32'(rx_busy), 32'h0);
        rst_n = 1'b1;
        idle_bits(14);
        check_frames("midreset_nostrobe");

        send_frame(8'h01, 1'b1, 2'b11, -1);
        send_frame(8'hFE, 1'b1, 2'b11, -1);
        idle_bits(1);
        check_frames("back_to_back");

        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            p   = ^d;
            st  = 2'b11;
            gap = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) p = ~p;
            if ($urandom_range(0, 3) == 0) st = 2'($urandom);
            if (d == 8'h00 && p == 1'b0 && st == 2'b00) st = 2'b11;
            if (st[0] == 1'b0 && gap == 0) gap = 1;
            send_frame(d, p, st, -1);
            idle_bits(gap);
        end
        idle_bits(2);
        check_frames("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial-to-parallel UART receiver that turns the asynchronous `Rx` line into parallel data words with per-frame error status. It oversamples the line, validates start, parity and stop bits, and detects break conditions. Each completed frame is presented as a one-cycle strobe toward the receive FIFO. It is the receiving end of the frame format produced by the UART transmitter, with the same parameter set.

## Interface
- `SYSCLK_RATE`, 100000000: `Clk` frequency in Hz.
- `BAUD_RATE`, 9600: line bit rate.
- `DATA_BITS`, 8: data bits per frame, legal range 5..8.
- `PARITY_BIT`, 1: 1 = even-parity bit present; 0 = no parity bit.
- `STOP_BITS`, 2: stop bits per frame, 1 or 2.
- `OVERSAMPLE`, 16: sample ticks per bit, even, at least 8.

Ports:
- `Clk` in 1: system clock.
- `Rst` in 1: reset, asynchronous, active-low.
- `Rx` in 1: serial line, idle high, asynchronous to `Clk`.
- `Data_Out` out DATA_BITS: last received word.
- `Data_Rdy` out 1: one-cycle strobe, frame complete.
- `Rx_Error` out 3: [0] break, [1] parity, [2] frame; valid with `Data_Rdy`.
- `Rx_Busy` out 1: high from start-bit detect until return to IDLE.

## Operation
- Frame on the line: start bit (0), then data MSB first, then parity bit if `PARITY_BIT`, then `STOP_BITS` stop bits (1).
- Parity rule: the parity bit equals the XOR of all data bits.
- `Rx` passes through a 2-flop synchronizer. All logic uses the synchronized value `rx_s`.
- Tick divisor = round(SYSCLK_RATE / (BAUD_RATE*OVERSAMPLE)), minimum 1. The tick counter is $clog2(divisor+1) bits wide and wraps to 0 on each tick.
- Bit value = majority of `rx_s` at tick indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.

FSM states and transitions:
- IDLE: on a 1→0 transition of `rx_s`, clear the tick counter and phase, then go to START.
- START: at the mid-bit vote, if the value is 1 it is a false start, so go to IDLE with no strobe. Otherwise go to DATA.
- DATA: shift in DATA_BITS bits. Then go to PARITY if `PARITY_BIT`, else STOP.
- PARITY: sample the parity bit and compare it with the running XOR.
- STOP: sample each stop bit. At the mid-point of the last stop bit:
  - update `Data_Out` and `Rx_Error` and pulse `Data_Rdy`;
  - go to BRK_WAIT if a break was detected, else IDLE.
- BRK_WAIT: stay until `rx_s`=1 for one full bit time, then go to IDLE.

Error bits:
- Break: start, all data bits, the parity bit and all stop bits sampled 0.
  - Sets only [0].
  - [1] and [2] are forced to 0.
  - `Data_Out` = 0.
- Frame: any stop bit samples 0 and the frame is not a break. Sets [2].
- Parity: mismatch. Sets [1]. It may coexist with [2].
- `Data_Out` and `Rx_Error` hold their value until the next strobe. Every completed frame, good or bad, produces exactly one `Data_Rdy`.

Reset:
- While `Rst`=0: state IDLE, synchronizer flops = 1, all counters 0, `Data_Out`=0, `Data_Rdy`=0, `Rx_Error`=0, `Rx_Busy`=0.
- Reset asserted mid-frame discards the partial frame and produces no strobe.
- A line still low after reset release is not a start, because start detection is edge-based.

## Timing
- From the `Rx` falling edge, the FSM enters START 3–4 `Clk` cycles later (synchronizer plus edge register).
- `Data_Rdy` rises in the cycle after the middle vote sample of the last stop bit. That is about (1 + DATA_BITS + PARITY_BIT + STOP_BITS − 0.5) bit times after the start edge, plus synchronizer delay.
- The receiver returns to IDLE in the same cycle as `Data_Rdy`, half a bit time before the stop bit ends. It accepts a new start edge from the next cycle, so back-to-back frames with zero idle are received.
- `Rx_Busy` falls in the same cycle as `Data_Rdy`, or on exit from BRK_WAIT after a break.
- There is no backpressure. The downstream FIFO must accept `Data_Rdy` unconditionally.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_e` enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT);
  - localparams `RX_ERR_BREAK`=0, `RX_ERR_PARITY`=1, `RX_ERR_FRAME`=2;
  - function `calc_divisor(sysclk, baud, os)`.
- Sub-module `uart_baud_tick`: parameterized divisor counter with a `clear` input and a one-cycle `tick` output. The transmitter reuses it with OVERSAMPLE=1.

## Test plan
Bench settings: SYSCLK_RATE=1600000, BAUD_RATE=100000, OVERSAMPLE=16 (divisor 1), DATA_BITS=8, PARITY_BIT=1, STOP_BITS=2.
- Valid frame 0xA5, parity 0 → one `Data_Rdy`, `Data_Out`=0xA5, `Rx_Error`=3'b000.
- Frame 0xAA with parity bit 1 → `Data_Out`=0xAA, `Rx_Error`=3'b010.
- Frame 0x3C with first stop bit 0 → `Rx_Error`=3'b100, `Data_Out`=0x3C.
- Line low for 40 bit times, then high → exactly one `Data_Rdy` with `Rx_Error`=3'b001 and `Data_Out`=0, then a following 0x55 frame is received clean.
- Glitches on `Rx`:
  - 3-cycle low glitch while idle → no `Data_Rdy`, `Rx_Busy` returns to 0 within 8 bit-ticks;
  - 1-cycle glitch mid data bit → data bit value unchanged (majority vote).
- Edge cases at the two ends of a frame:
  - `Rst` pulsed low at data bit 4 of a frame → no strobe, outputs zeroed;
  - two back-to-back frames 0x01 and 0xFE with no idle → two strobes carrying the correct data.
